// File: rtl/usb_tx_fsm_if.sv
// Packet-layer to USB transmit sequencer handshake (UTMI-style TXValid/TXReady).
// The tx_abort request exists only when USB_TX_ABORT_EN is defined.
interface usb_tx_fsm_if;
    logic       TXValid;
    logic [7:0] DataIn;
    logic       TXReady;
`ifdef USB_TX_ABORT_EN
    logic       tx_abort;

    modport master (output TXValid, output DataIn, output tx_abort, input TXReady);
    modport slave  (input TXValid, input DataIn, input tx_abort, output TXReady);
`else
    modport master (output TXValid, output DataIn, input TXReady);
    modport slave  (input TXValid, input DataIn, output TXReady);
`endif
endinterface

// File: rtl/usb_tx_fsm.sv
// USB full-speed transmit sequencer: SYNC, LSB-first bit-stuffed NRZI data, EOP on dp/dm.
// Optional packet abort (8 unstuffed ones, then EOP) is compiled in with USB_TX_ABORT_EN.
module usb_tx_fsm #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          nRST,
    usb_tx_fsm_if.slave   tx,
    output logic          dp,
    output logic          dm,
    output logic          tx_oe,
    output logic          tx_busy,
    output logic          frame_sent
);

    localparam int             TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
`ifdef USB_TX_ABORT_EN
        , S_ABORT
`endif
    } state_t;

    state_t         state;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_cnt;    // data bit index, SE0 period or abort bit, depending on state
    logic [2:0]     ones_cnt;
    logic [7:0]     data_q;
    logic           stuffing;   // current bit period is a stuffed zero
    logic           boundary;
    logic           cap_slot;
    logic           take;

    function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
        return b ? line : ~line;
    endfunction

    function automatic logic [2:0] ones_next(input logic [2:0] cnt, input logic b);
        return b ? cnt + 3'd1 : 3'd0;
    endfunction

    assign boundary = (timer == T_LAST);

    // A byte may be taken only at the end of SYNC or at the end of the last data bit
    // when no stuffed zero is still owed.
    assign cap_slot = boundary && (bit_cnt == 3'd7) &&
                      ((state == S_SYNC) || ((state == S_DATA) && (ones_cnt != 3'd6)));

`ifdef USB_TX_ABORT_EN
    logic abort_pend;
    logic abort_req;

    assign abort_req = abort_pend | tx.tx_abort;
    assign take      = cap_slot & tx.TXValid & ~abort_req;
`else
    assign take      = cap_slot & tx.TXValid;
`endif

    assign tx.TXReady = take;

    // NOTE: every state register uses non-blocking assignment so all updates in this
    // block see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            data_q     <= '0;
            stuffing   <= 1'b0;
            {dp, dm}   <= LINE_J;
            tx_oe      <= 1'b0;
            tx_busy    <= 1'b0;
            frame_sent <= 1'b0;
`ifdef USB_TX_ABORT_EN
            abort_pend <= 1'b0;
`endif
        end else begin
            frame_sent <= 1'b0;
            if (state != S_IDLE) begin
                timer <= boundary ? '0 : timer + 1'b1;
            end
`ifdef USB_TX_ABORT_EN
            if ((state == S_SYNC || state == S_DATA) && tx.tx_abort) begin
                abort_pend <= 1'b1;
            end
`endif
            case (state)
                S_IDLE: begin
                    {dp, dm} <= LINE_J;
                    if (tx.TXValid) begin
                        state    <= S_SYNC;
                        tx_oe    <= 1'b1;
                        tx_busy  <= 1'b1;
                        {dp, dm} <= LINE_K;
                        timer    <= '0;
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                        stuffing <= 1'b0;
                    end
                end

                S_SYNC: begin
                    if (boundary) begin
`ifdef USB_TX_ABORT_EN
                        if (abort_req) begin
                            state      <= S_ABORT;
                            bit_cnt    <= '0;
                            abort_pend <= 1'b0;
                        end else
`endif
                        if (bit_cnt != 3'd7) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            {dp, dm} <= nrzi({dp, dm}, bit_cnt == 3'd6);
                            ones_cnt <= (bit_cnt == 3'd6) ? 3'd1 : 3'd0;
                        end else if (take) begin
                            state    <= S_DATA;
                            data_q   <= tx.DataIn;
                            bit_cnt  <= '0;
                            {dp, dm} <= nrzi({dp, dm}, tx.DataIn[0]);
                            ones_cnt <= ones_next(ones_cnt, tx.DataIn[0]);
                        end else begin
                            state    <= S_EOP_SE0;
                            bit_cnt  <= '0;
                            {dp, dm} <= LINE_SE0;
                        end
                    end
                end

                S_DATA: begin
                    if (boundary) begin
`ifdef USB_TX_ABORT_EN
                        if (abort_req) begin
                            state      <= S_ABORT;
                            bit_cnt    <= '0;
                            stuffing   <= 1'b0;
                            abort_pend <= 1'b0;
                        end else
`endif
                        if (ones_cnt == 3'd6) begin
                            stuffing <= 1'b1;
                            ones_cnt <= '0;
                            {dp, dm} <= ~{dp, dm};
                        end else if (bit_cnt != 3'd7) begin
                            stuffing <= 1'b0;
                            bit_cnt  <= bit_cnt + 3'd1;
                            {dp, dm} <= nrzi({dp, dm}, data_q[bit_cnt + 3'd1]);
                            ones_cnt <= ones_next(ones_cnt, data_q[bit_cnt + 3'd1]);
                        end else if (take) begin
                            stuffing <= 1'b0;
                            data_q   <= tx.DataIn;
                            bit_cnt  <= '0;
                            {dp, dm} <= nrzi({dp, dm}, tx.DataIn[0]);
                            ones_cnt <= ones_next(ones_cnt, tx.DataIn[0]);
                        end else begin
                            stuffing <= 1'b0;
                            state    <= S_EOP_SE0;
                            bit_cnt  <= '0;
                            {dp, dm} <= LINE_SE0;
                        end
                    end
                end

                S_EOP_SE0: begin
                    if (boundary) begin
                        if (bit_cnt == 3'd1) begin
                            state    <= S_EOP_J;
                            bit_cnt  <= '0;
                            {dp, dm} <= LINE_J;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                S_EOP_J: begin
                    if (boundary) begin
                        state      <= S_IDLE;
                        tx_oe      <= 1'b0;
                        tx_busy    <= 1'b0;
                        frame_sent <= 1'b1;
                    end
                end

`ifdef USB_TX_ABORT_EN
                S_ABORT: begin
                    // Line level is simply held: eight unstuffed ones.
                    if (boundary) begin
                        if (bit_cnt == 3'd7) begin
                            state    <= S_EOP_SE0;
                            bit_cnt  <= '0;
                            {dp, dm} <= LINE_SE0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_fsm.sv
// Self-checking bench for usb_tx_fsm: randomized and directed packets checked against a
// bit-stream model (SYNC + stuffed data + EOP, NRZI-encoded) built from the packet bytes.
module tb_usb_tx_fsm;

    localparam int CPB   = 4;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic nRST;
    logic dp, dm, tx_oe, tx_busy, frame_sent;

    usb_tx_fsm_if tx_bus ();

    usb_tx_fsm #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .tx         (tx_bus),
        .dp         (dp),
        .dm         (dm),
        .tx_oe      (tx_oe),
        .tx_busy    (tx_busy),
        .frame_sent (frame_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pkt[$];
    logic [1:0] trace[$];
    int         cap_idx[$];
    logic [1:0] exp_line[$];
    int         exp_cap[$];
    int         frame_cnt = 0;
    int         frames    = 0;
    int         busy_err  = 0;
    int         rdy_err   = 0;

    // Line monitor: one sample per clk while the driver is enabled.
    always @(negedge clk) begin
        if (tx_oe === 1'b1) trace.push_back({dp, dm});
        if (tx_bus.TXReady === 1'b1 && tx_bus.TXValid === 1'b1) cap_idx.push_back(trace.size() - 1);
        if (tx_bus.TXReady === 1'b1 && tx_bus.TXValid !== 1'b1) rdy_err++;
        if (frame_sent === 1'b1) frame_cnt++;
        if (tx_busy !== tx_oe) busy_err++;
    end

    // Expected line per bit period and expected capture clocks, from the packet bytes.
    task automatic build_model();
        logic bits[$];
        int   first_pos[$];
        int   ones;
        logic [1:0] lvl;
        logic [7:0] b;
        exp_line.delete();
        exp_cap.delete();
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        ones = 1;
        for (int k = 0; k < pkt.size(); k++) begin
            b = pkt[k];
            first_pos.push_back(bits.size());
            for (int j = 0; j < 8; j++) begin
                bits.push_back(b[j]);
                ones = b[j] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl = 2'b10;
        for (int i = 0; i < bits.size(); i++) begin
            if (!bits[i]) lvl = ~lvl;
            exp_line.push_back(lvl);
        end
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b10);
        for (int k = 0; k < first_pos.size(); k++) exp_cap.push_back(first_pos[k] * CPB - 1);
    endtask

    function automatic int line_errs();
        int e = 0;
        if (trace.size() != exp_line.size() * CPB) e++;
        for (int i = 0; i < trace.size(); i++) begin
            if (i / CPB >= exp_line.size()) e++;
            else if (trace[i] !== exp_line[i / CPB]) e++;
        end
        return e;
    endfunction

    function automatic int cap_errs();
        int e = 0;
        if (cap_idx.size() != exp_cap.size()) e++;
        for (int i = 0; i < cap_idx.size() && i < exp_cap.size(); i++) begin
            if (cap_idx[i] != exp_cap[i]) e++;
        end
        return e;
    endfunction

    // Drives pkt through the handshake; abort_at = transfer count after which tx_abort rises.
    task automatic run_packet(input int abort_at, output bit timed_out);
        int f0;
        int idx;
        int cyc;
        bit done;
        cyc = 0;
        while (tx_oe !== 1'b0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        trace.delete();
        cap_idx.delete();
        f0   = frame_cnt;
        idx  = 0;
        done = 1'b0;
        @(posedge clk);
        #1;
        tx_bus.TXValid = 1'b1;
        tx_bus.DataIn  = (pkt.size() > 0) ? pkt[0] : 8'h00;
        if (pkt.size() == 0) begin
            @(posedge clk);
            #1 tx_bus.TXValid = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (frame_cnt != f0) begin
                done = 1'b1;
            end else if (tx_bus.TXReady === 1'b1 && tx_bus.TXValid === 1'b1) begin
                @(posedge clk);
                #1;
                idx++;
                if (idx < pkt.size()) begin
                    tx_bus.DataIn = pkt[idx];
                end else begin
                    tx_bus.TXValid = 1'b0;
                    tx_bus.DataIn  = 8'($urandom);
                end
`ifdef USB_TX_ABORT_EN
                if (idx == abort_at) tx_bus.tx_abort = 1'b1;
`endif
            end
        end
        tx_bus.TXValid = 1'b0;
`ifdef USB_TX_ABORT_EN
        tx_bus.tx_abort = 1'b0;
`endif
        timed_out = !done;
        repeat (3) @(negedge clk);
        frames = frame_cnt - f0;
    endtask

    task automatic test_reset();
        nRST           = 1'b0;
        tx_bus.TXValid = 1'b0;
        tx_bus.DataIn  = 8'h00;
`ifdef USB_TX_ABORT_EN
        tx_bus.tx_abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks++; if ({dp, dm} !== 2'b10) $display("FAIL reset_line: got %b want 10", {dp, dm}); else n_pass++;
        n_checks++; if (tx_oe !== 1'b0) $display("FAIL reset_tx_oe: got %b want 0", tx_oe); else n_pass++;
        n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b want 0", tx_busy); else n_pass++;
        n_checks++; if (frame_sent !== 1'b0) $display("FAIL reset_frame_sent: got %b want 0", frame_sent); else n_pass++;
        n_checks++; if (tx_bus.TXReady !== 1'b0) $display("FAIL reset_txready: got %b want 0", tx_bus.TXReady); else n_pass++;
        @(posedge clk);
        #1 nRST = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_oe !== 1'b0 || {dp, dm} !== 2'b10) $display("FAIL idle_after_reset: tx_oe=%b line=%b want 0/10", tx_oe, {dp, dm}); else n_pass++;
    endtask

    task automatic test_single_zero();
        bit to;
        pkt = '{8'h00};
        build_model();
        run_packet(-1, to);
        n_checks++; if (to) $display("FAIL single_zero_timeout: no frame_sent within %0d clks", LIMIT); else n_pass++;
        n_checks++; if (trace.size() != 76) $display("FAIL single_zero_oe_len: got %0d clks want 76", trace.size()); else n_pass++;
        n_checks++; if (line_errs() != 0) $display("FAIL single_zero_line: %0d bad clks want 0", line_errs()); else n_pass++;
        n_checks++; if (cap_errs() != 0) $display("FAIL single_zero_txready: %0d pulses, %0d errors want %0d pulses", cap_idx.size(), cap_errs(), exp_cap.size()); else n_pass++;
        n_checks++; if (frames != 1) $display("FAIL single_zero_frame_sent: got %0d want 1", frames); else n_pass++;
    endtask

    task automatic test_bit_stuffing();
        bit to;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: pkt = '{8'hFF};
                1: pkt = '{8'hFC};
                default: pkt = '{8'hFF, 8'hFF, 8'hFC, 8'h00};
            endcase
            build_model();
            run_packet(-1, to);
            n_checks++; if (to) $display("FAIL stuff%0d_timeout: no frame_sent within %0d clks", p, LIMIT); else n_pass++;
            n_checks++; if (line_errs() != 0) $display("FAIL stuff%0d_line: %0d bad clks, got %0d clks want %0d", p, line_errs(), trace.size(), exp_line.size() * CPB); else n_pass++;
            n_checks++; if (cap_errs() != 0) $display("FAIL stuff%0d_txready: %0d errors, %0d pulses want %0d", p, cap_errs(), cap_idx.size(), exp_cap.size()); else n_pass++;
            n_checks++; if (frames != 1) $display("FAIL stuff%0d_frame_sent: got %0d want 1", p, frames); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int gap;
        pkt = '{8'hA5, 8'h3C};
        build_model();
        run_packet(-1, to);
        gap = (cap_idx.size() == 2) ? cap_idx[1] - cap_idx[0] : -1;
        n_checks++; if (to) $display("FAIL b2b_timeout: no frame_sent within %0d clks", LIMIT); else n_pass++;
        n_checks++; if (gap != 8 * CPB) $display("FAIL b2b_spacing: got %0d clks want %0d", gap, 8 * CPB); else n_pass++;
        n_checks++; if (line_errs() != 0) $display("FAIL b2b_line: %0d bad clks want 0", line_errs()); else n_pass++;
        n_checks++; if (cap_errs() != 0) $display("FAIL b2b_txready: %0d errors want 0", cap_errs()); else n_pass++;
        n_checks++; if (frames != 1) $display("FAIL b2b_frame_sent: got %0d want 1", frames); else n_pass++;
    endtask

    task automatic test_zero_length();
        bit to;
        pkt.delete();
        build_model();
        run_packet(-1, to);
        n_checks++; if (to) $display("FAIL zlp_timeout: no frame_sent within %0d clks", LIMIT); else n_pass++;
        n_checks++; if (line_errs() != 0) $display("FAIL zlp_line: %0d bad clks, got %0d clks want %0d", line_errs(), trace.size(), exp_line.size() * CPB); else n_pass++;
        n_checks++; if (cap_idx.size() != 0) $display("FAIL zlp_txready: got %0d pulses want 0", cap_idx.size()); else n_pass++;
        n_checks++; if (frames != 1) $display("FAIL zlp_frame_sent: got %0d want 1", frames); else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        bit to;
        @(posedge clk);
        #1;
        tx_bus.TXValid = 1'b1;
        tx_bus.DataIn  = 8'h00;
        repeat (44) @(posedge clk);
        #1;
        n_checks++; if (tx_oe !== 1'b1) $display("FAIL midrst_pre_oe: got %b want 1", tx_oe); else n_pass++;
        nRST = 1'b0;
        #1;
        n_checks++; if ({dp, dm} !== 2'b10) $display("FAIL midrst_line: got %b want 10", {dp, dm}); else n_pass++;
        n_checks++; if (tx_oe !== 1'b0) $display("FAIL midrst_tx_oe: got %b want 0", tx_oe); else n_pass++;
        n_checks++; if (tx_busy !== 1'b0) $display("FAIL midrst_tx_busy: got %b want 0", tx_busy); else n_pass++;
        tx_bus.TXValid = 1'b0;
        repeat (2) @(posedge clk);
        #1 nRST = 1'b1;
        pkt = '{8'h5A};
        build_model();
        run_packet(-1, to);
        n_checks++; if (to) $display("FAIL midrst_after_timeout: no frame_sent within %0d clks", LIMIT); else n_pass++;
        n_checks++; if (line_errs() != 0) $display("FAIL midrst_after_line: %0d bad clks want 0", line_errs()); else n_pass++;
        n_checks++; if (frames != 1) $display("FAIL midrst_after_frame_sent: got %0d want 1", frames); else n_pass++;
    endtask

    task automatic test_random();
        bit to;
        int len;
        for (int p = 0; p < 6; p++) begin
            pkt.delete();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            build_model();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_packet(-1, to);
            n_checks++; if (to) $display("FAIL rand%0d_timeout: no frame_sent within %0d clks", p, LIMIT); else n_pass++;
            n_checks++; if (line_errs() != 0) $display("FAIL rand%0d_line: %0d bad clks, got %0d clks want %0d", p, line_errs(), trace.size(), exp_line.size() * CPB); else n_pass++;
            n_checks++; if (cap_errs() != 0) $display("FAIL rand%0d_txready: %0d errors, %0d pulses want %0d", p, cap_errs(), cap_idx.size(), exp_cap.size()); else n_pass++;
            n_checks++; if (frames != 1) $display("FAIL rand%0d_frame_sent: got %0d want 1", p, frames); else n_pass++;
        end
    endtask

`ifdef USB_TX_ABORT_EN
    task automatic test_abort();
        bit to;
        int n;
        int bad;
        pkt = '{8'h12, 8'h34, 8'h56};
        run_packet(2, to);
        n   = trace.size();
        bad = 0;
        if (n < 45) bad++;
        else begin
            for (int i = n - 4; i < n; i++) if (trace[i] !== 2'b10) bad++;
            for (int i = n - 12; i < n - 4; i++) if (trace[i] !== 2'b00) bad++;
            for (int i = n - 45; i < n - 12; i++) if (trace[i] !== trace[n - 44]) bad++;
            if ((n - 44) % CPB != 0) bad++;
        end
        n_checks++; if (to) $display("FAIL abort_timeout: no frame_sent within %0d clks", LIMIT); else n_pass++;
        n_checks++; if (cap_idx.size() != 2) $display("FAIL abort_txready: got %0d pulses want 2", cap_idx.size()); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL abort_line: %0d bad clks in abort/EOP tail want 0", bad); else n_pass++;
        n_checks++; if (frames != 1) $display("FAIL abort_frame_sent: got %0d want 1", frames); else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_zero();
        test_bit_stuffing();
        test_back_to_back();
        test_zero_length();
        test_reset_mid_data();
        test_random();
`ifdef USB_TX_ABORT_EN
        test_abort();
`endif
        n_checks++; if (busy_err != 0) $display("FAIL busy_vs_oe: %0d clks differ want 0", busy_err); else n_pass++;
        n_checks++; if (rdy_err != 0) $display("FAIL txready_without_txvalid: %0d clks want 0", rdy_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
